// File: rtl/line_byte_packer_pkg.sv
// Shared types and helpers for the line byte packer.
// Byte order: LINE_BYTE_PACKER_MSB_FIRST_EN puts the first byte of a word in bits [31:24].
package line_byte_packer_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

    typedef logic [1:0] lane_t;

`ifdef LINE_BYTE_PACKER_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    // Physical byte slot of a logical lane (lane 0 = first byte of the word).
    function automatic lane_t lane_byte_pos(input lane_t lane);
        return MSB_FIRST ? lane_t'(2'd3 - lane) : lane;
    endfunction

    function automatic logic [3:0] keep_mask(input logic [2:0] nbytes);
        logic [3:0] m;
        case (nbytes)
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd3:    m = 4'b0111;
            3'd4:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return MSB_FIRST ? {m[0], m[1], m[2], m[3]} : m;
    endfunction

endpackage

// File: rtl/line_byte_packer_oreg.sv
// Output word register with valid/ready hold; load_en tells the packer its word was taken.
module line_byte_packer_oreg
    import line_byte_packer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic [WORD_W-1:0] in_data,
    input  logic [3:0]        in_keep,
    input  logic              in_sol,
    input  logic              in_last,
    output logic              load_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [3:0]        out_keep,
    output logic              out_sol,
    output logic              out_last
);

    assign load_en = load_req && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_sol   <= 1'b0;
            out_last  <= 1'b0;
        end else if (load_en) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_keep  <= in_keep;
            out_sol   <= in_sol;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/line_byte_packer.sv
// Pops bytes from the line FIFO and packs them into 32-bit words framed per video line.
// Byte order selected by LINE_BYTE_PACKER_MSB_FIRST_EN (see package).
module line_byte_packer
    import line_byte_packer_pkg::*;
#(
    parameter int LEN_W = 11,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_rd_vld,
    input  logic [7:0]       fifo_rd_data,
    output logic             fifo_rd_en,
    input  logic [LEN_W-1:0] line_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [3:0]       out_keep,
    output logic             out_sol,
    output logic             out_last,
    output logic [CNT_W-1:0] lines_done
);

    localparam logic [LEN_W:0] REM_ONE  = (LEN_W+1)'(1);
    localparam logic [LEN_W:0] REM_FULL = {1'b1, {LEN_W{1'b0}}};

    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] acc_d;
    lane_t             acc_cnt_q;
    logic              acc_full_q;
    logic              acc_sol_q;
    logic              acc_last_q;
    logic [3:0]        acc_keep_q;
    logic              in_line_q;
    logic [LEN_W:0]    rem_q;
    logic [LEN_W:0]    rem_eff;
    logic [CNT_W-1:0]  lines_done_q;
    logic              xfer;
    logic              pop;
    logic              line_start;
    logic              final_byte;
    logic              word_done;

    assign fifo_rd_en = fifo_rd_vld && !rst && (!acc_full_q || xfer);
    assign pop        = fifo_rd_en;
    assign line_start = !in_line_q;

    // line_len only matters on the first byte of a line; 0 encodes a full 2^LEN_W line
    always_comb begin
        rem_eff = rem_q;
        if (line_start) begin
            rem_eff = (line_len == '0) ? REM_FULL : {1'b0, line_len};
        end
    end

    assign final_byte = (rem_eff == REM_ONE);
    assign word_done  = final_byte || (acc_cnt_q == lane_t'(BYTES_PER_WORD - 1));

    // A word leaving on xfer frees acc, so a same-cycle pop starts from a clean word
    always_comb begin
        acc_d = xfer ? '0 : acc_q;
        if (pop) begin
            acc_d[{lane_byte_pos(acc_cnt_q), 3'b000} +: 8] = fifo_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            acc_full_q   <= 1'b0;
            acc_sol_q    <= 1'b0;
            acc_last_q   <= 1'b0;
            acc_keep_q   <= '0;
            in_line_q    <= 1'b0;
            rem_q        <= '0;
            lines_done_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (pop) begin
                acc_cnt_q  <= word_done ? '0 : acc_cnt_q + lane_t'(1);
                acc_full_q <= word_done;
                if (word_done) begin
                    acc_keep_q <= keep_mask({1'b0, acc_cnt_q} + 3'd1);
                    acc_last_q <= final_byte;
                end
                if (acc_cnt_q == '0) begin
                    acc_sol_q <= line_start;
                end
                rem_q     <= rem_eff - REM_ONE;
                in_line_q <= !final_byte;
            end else if (xfer) begin
                acc_full_q <= 1'b0;
            end
            if (out_valid && out_ready && out_last) begin
                lines_done_q <= lines_done_q + CNT_W'(1);
            end
        end
    end

    assign lines_done = lines_done_q;

    line_byte_packer_oreg u_oreg (
        .clk       (clk),
        .rst       (rst),
        .load_req  (acc_full_q),
        .in_data   (acc_q),
        .in_keep   (acc_keep_q),
        .in_sol    (acc_sol_q),
        .in_last   (acc_last_q),
        .load_en   (xfer),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_sol   (out_sol),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_line_byte_packer.sv
// Scoreboard bench for line_byte_packer: FIFO model feeds bytes, expected words queued per line.
module tb_line_byte_packer;

    localparam int LEN_W = 11;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             fifo_rd_vld = 1'b0;
    logic [7:0]       fifo_rd_data = 8'h00;
    logic             fifo_rd_en;
    logic [LEN_W-1:0] line_len = 11'd8;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_data;
    logic [3:0]       out_keep;
    logic             out_sol;
    logic             out_last;
    logic [CNT_W-1:0] lines_done;

    line_byte_packer #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_rd_vld  (fifo_rd_vld),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .line_len     (line_len),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_keep     (out_keep),
        .out_sol      (out_sol),
        .out_last     (out_last),
        .lines_done   (lines_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        sol;
        logic        last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_lines = 0;
    int         stall_cnt = 0;
    bit         stall_arm = 0;
    bit         rand_ready = 0;
    logic       pop_seen = 1'b0;

    always @(posedge clk) pop_seen <= fifo_rd_en;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_line(input int n, input logic [7:0] first);
        exp_t       e;
        int         lane;
        logic [7:0] b;
        logic [3:0] k;
        lane   = 0;
        e.data = '0;
        e.keep = '0;
        e.sol  = 1'b1;
        e.last = 1'b0;
        for (int i = 0; i < n; i++) begin
            b = first + 8'(i);
`ifdef LINE_BYTE_PACKER_MSB_FIRST_EN
            e.data[(3 - lane) * 8 +: 8] = b;
`else
            e.data[lane * 8 +: 8] = b;
`endif
            lane++;
            if (lane == 4 || i == n - 1) begin
                k = 4'hF;
`ifdef LINE_BYTE_PACKER_MSB_FIRST_EN
                k = k << (4 - lane);
`else
                k = k >> (4 - lane);
`endif
                e.keep = k;
                e.last = (i == n - 1);
                exp_q.push_back(e);
                e.data = '0;
                e.sol  = 1'b0;
                lane   = 0;
            end
        end
    endtask

    task automatic feed_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(first + 8'(i));
    endtask

    // One cycle: retire the byte popped at the last edge, drive inputs, check any accepted word.
    task automatic step();
        exp_t e;
        bit   stall_end;
        @(negedge clk);
        if (pop_seen && fifo_q.size() > 0) fifo_q.delete(0);
        fifo_rd_vld  = (fifo_q.size() > 0);
        fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        stall_end = (stall_cnt == 1);
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        #1;
        if (stall_end) begin
            check_val("stall_rd_en", 32'(fifo_rd_en), 32'd0);
            check_val("stall_bytes_left", 32'(fifo_q.size()), 32'd4);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_word", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("data", out_data, e.data);
                check_val("keep", 32'(out_keep), 32'(e.keep));
                check_val("sol", 32'(out_sol), 32'(e.sol));
                check_val("last", 32'(out_last), 32'(e.last));
                if (e.last) exp_lines++;
            end
            if (stall_arm) begin
                stall_arm = 0;
                stall_cnt = 10;
            end
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || fifo_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        check_val(tag, 32'(exp_q.size()), 32'd0);
        step();
        step();
        check_val({tag, "_lines_done"}, 32'(lines_done), 32'(exp_lines));
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step();
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_data", out_data, 32'd0);
        check_val("rst_keep", 32'(out_keep), 32'd0);
        check_val("rst_sol_last", 32'({out_sol, out_last}), 32'd0);
        check_val("rst_lines_done", 32'(lines_done), 32'd0);
        check_val("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        rst = 1'b0;

        // 8-byte line, free-flowing
        line_len = 11'd8;
        model_line(8, 8'h01);
        feed_bytes(8'h01, 8);
        wait_drain("len8", 200);

        // 6-byte line ends with a partial word; following line restarts at lane 0
        line_len = 11'd6;
        model_line(6, 8'hA0);
        feed_bytes(8'hA0, 6);
        wait_drain("len6", 200);
        line_len = 11'd8;
        model_line(8, 8'hB0);
        feed_bytes(8'hB0, 8);
        wait_drain("len8_after6", 200);

        // backpressure: 10 stalled cycles after the first word
        line_len  = 11'd16;
        model_line(16, 8'h00);
        feed_bytes(8'h00, 16);
        stall_arm = 1;
        wait_drain("len16_stall", 400);

        // FIFO empty mid-word
        line_len = 11'd4;
        model_line(4, 8'hC0);
        feed_bytes(8'hC0, 2);
        repeat (7) step();
        check_val("gap_no_valid", 32'(out_valid), 32'd0);
        check_val("gap_bytes_taken", 32'(fifo_q.size()), 32'd0);
        feed_bytes(8'hC2, 2);
        wait_drain("gap", 200);

        // reset mid-line discards the partial word
        line_len = 11'd8;
        feed_bytes(8'hD0, 3);
        for (int i = 0; i < 20 && fifo_q.size() > 0; i++) step();
        step();
        rst       = 1'b1;
        exp_lines = 0;
        line_len  = 11'd4;
        model_line(4, 8'h11);
        feed_bytes(8'h11, 4);
        step();
        check_val("midrst_valid", 32'(out_valid), 32'd0);
        check_val("midrst_data", out_data, 32'd0);
        check_val("midrst_keep", 32'(out_keep), 32'd0);
        check_val("midrst_sol_last", 32'({out_sol, out_last}), 32'd0);
        check_val("midrst_lines_done", 32'(lines_done), 32'd0);
        check_val("midrst_no_pop", 32'(fifo_q.size()), 32'd4);
        rst = 1'b0;
        wait_drain("after_rst", 200);

        // line_len 0 = 2048 bytes, random backpressure; mid-line change applies to next line
        rand_ready = 1;
        line_len   = 11'd0;
        model_line(2048, 8'h01);
        feed_bytes(8'h01, 2048);
        model_line(8, 8'hE0);
        feed_bytes(8'hE0, 8);
        repeat (100) step();
        line_len = 11'd8;
        wait_drain("len2048", 20000);
        rand_ready = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
